scb_sim_port_fabric: RTL and testbench
======================================

// Module: scb_sim_port_fabric
// PURPOSE
// Simulation stand-in for the switch core inside a multi-switch testbench.
// Moves 18-bit PCS lane words between N ports ({k[1:0],data[15:0]} per lane) through a
// per-output route table, and tracks link state per port.
// Exposes a 32-bit pipelined Wishbone slave for CPU access and raises an IRQ on link change.
// PARAMETERS
// g_num_ports  18  number of lanes/ports (1..32)
// PORTS
// clk_ref_i    in   1        single clock for all logic
// sys_rst_n_i  in   1        reset, synchronous, active-low
// wb_adr_i     in   32       byte address; only [7:2] decoded
// wb_dat_i     in   32       write data
// wb_dat_o     out  32       read data, valid with wb_ack_o
// wb_cyc_i     in   1        bus cycle
// wb_stb_i     in   1        strobe
// wb_we_i      in   1        write enable
// wb_sel_i     in   4        byte enables
// wb_ack_o     out  1        transfer acknowledge
// wb_stall_o   out  1        always 0
// wb_irq_o     out  1        |(IRQ_STATUS & IRQ_MASK)
// pps_i        in   1        pulse-per-second input
// rd_i         in   18*N     lane p = rd_i[18p+17:18p]; [17:16]=k, [15:0]=data
// td_o         out  18*N     same packing as rd_i
// BEHAVIOUR
// - Reset (sync): td_o lanes=IDLE {2'b10,16'hBC50}; wb_ack_o=0; wb_dat_o=0; irq=0.
//   Reset also clears routes (disabled), masks, link status, counters and shadow state.
// - DOWN word = {2'b01,16'h00BC} (fill driven by a dead endpoint).
// - Link detect per port:
//   - 4-bit run counter; counter restarts when the class (DOWN / non-DOWN) changes.
//   - 16 consecutive DOWN words -> LINK[p]=0.
//   - 16 consecutive non-DOWN words -> LINK[p]=1.
//   - Any change of LINK[p] sets IRQ_STATUS[p] in the same cycle LINK updates.
// - Forwarding: td_o[p] registered, 1-cycle latency from rd_i:
//   - ROUTE[p].en=1 and src<N -> td_o[p] = rd_i[src].
//   - Otherwise -> IDLE.
//   - Several outputs may select the same src (broadcast allowed).
//   - src==p is a legal loopback.
// - Wishbone (classic pipelined):
//   - Stall never asserted.
//   - wb_ack_o=1 exactly one cycle after each clock where cyc&stb=1; back-to-back accepted.
//   - Writes apply per byte via wb_sel_i.
//   - Unmapped reads return 0; unmapped writes ignored; no err.
// - Register map (byte offsets):
//   - 0x00 ID RO = 32'h5CB5_F00D
//   - 0x04 LINK_STATUS RO, bit p = LINK[p]
//   - 0x08 IRQ_STATUS W1C
//   - 0x0C IRQ_MASK RW
//   - 0x10 PPS_CNT RO: +1 on each pps_i rising edge; wraps 0xFFFFFFFF->0
//   - 0x40+4p ROUTE[p] RW: [31]=en, [4:0]=src; other bits read 0
// - Simultaneous W1C and set of the same IRQ bit: set wins (bit remains 1).
// - ROUTE write takes effect on td_o two cycles after the accepted strobe (reg update + lane reg).
// - Bits >= g_num_ports in LINK/IRQ registers read 0.
// TESTING
// - Reset -> all td_o lanes 18'h2BC50, LINK_STATUS=0, ID read = 5CB5F00D with ack 1 cycle later.
// - rd_i[3] = 18'h2BC50 for 16 cycles, IRQ_MASK=8 ->
//   - LINK_STATUS=0x8, wb_irq_o=1.
//   - Writing 0x8 to 0x08 clears the IRQ.
// - Then rd_i[3] = DOWN for 16 cycles -> LINK_STATUS=0, IRQ_STATUS[3]=1.
//   - 15 cycles of DOWN alone leave LINK[3]=1.
// - ROUTE[7] = 0x8000_0002, rd_i[2]=18'h1_1234 -> td_o[7]=18'h1_1234 one cycle later.
//   - ROUTE[7] = 0x8000_001F (src>=N) -> td_o[7] = IDLE.
// - Back-to-back strobes, 5 cycles, write 0x40 then read 0x40 ->
//   - 5 acks, one per cycle; read data 0x8000_0001 for written 0x8000_0001.
//   - sel=4'b0001 write leaves en unchanged.
// - 3 pps_i pulses -> PPS_CNT=3.
//   - W1C of IRQ bit in the same cycle a new link change sets it -> bit stays 1.

Source files
------------

// File: rtl/scb_sim_port_fabric.sv
// Simulation stand-in for a switch core: routes 18-bit PCS lane words between ports,
// tracks per-port link state and exposes a pipelined Wishbone register slave.
module scb_sim_port_fabric #(
  parameter int g_num_ports = 18
) (
  input  logic                      clk_ref_i,
  input  logic                      sys_rst_n_i,
  input  logic [31:0]               wb_adr_i,
  input  logic [31:0]               wb_dat_i,
  output logic [31:0]               wb_dat_o,
  input  logic                      wb_cyc_i,
  input  logic                      wb_stb_i,
  input  logic                      wb_we_i,
  input  logic [3:0]                wb_sel_i,
  output logic                      wb_ack_o,
  output logic                      wb_stall_o,
  output logic                      wb_irq_o,
  input  logic                      pps_i,
  input  logic [18*g_num_ports-1:0] rd_i,
  output logic [18*g_num_ports-1:0] td_o
);

  localparam int          N         = g_num_ports;
  localparam logic [17:0] IDLE_WORD = 18'h2BC50;
  localparam logic [17:0] DOWN_WORD = 18'h100BC;
  localparam logic [31:0] ID_VALUE  = 32'h5CB5_F00D;
  localparam logic [31:0] PORT_MASK = (N >= 32) ? 32'hFFFF_FFFF : ((32'd1 << N) - 32'd1);

  logic [N-1:0]       link_q, link_d;
  logic [N-1:0]       cls_q, cls_d;
  logic [N-1:0][3:0]  cnt_q, cnt_d;
  logic [31:0]        irq_status_q, irq_status_d;
  logic [31:0]        irq_mask_q, irq_mask_d;
  logic [31:0]        pps_cnt_q, pps_cnt_d;
  logic               pps_q, pps_d;
  logic [N-1:0]       route_en_q, route_en_d;
  logic [N-1:0][4:0]  route_src_q, route_src_d;
  logic [N-1:0][17:0] td_q, td_d;
  logic               ack_q, ack_d;
  logic [31:0]        dat_q, dat_d;

  logic        acc;
  logic        wr;
  logic [5:0]  idx;
  logic [31:0] bmask;
  logic [31:0] rdata;
  logic [31:0] link_chg;
  logic [31:0] w1c;
  logic        unused_adr;

  assign unused_adr = ^{wb_adr_i[31:8], wb_adr_i[1:0]};

  always_comb begin
    acc          = wb_cyc_i & wb_stb_i;
    wr           = acc & wb_we_i;
    idx          = wb_adr_i[7:2];
    bmask        = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
    link_d       = link_q;
    cls_d        = cls_q;
    cnt_d        = cnt_q;
    irq_mask_d   = irq_mask_q;
    pps_cnt_d    = pps_cnt_q;
    pps_d        = pps_i;
    route_en_d   = route_en_q;
    route_src_d  = route_src_q;
    td_d         = td_q;
    link_chg     = '0;
    w1c          = '0;
    rdata        = '0;

    // cls_q holds the class of the current run (1 = DOWN); cnt_q saturates at 15,
    // so a matching word arriving with cnt_q==15 is the 16th of the run.
    for (int p = 0; p < N; p++) begin
      if ((rd_i[18*p +: 18] == DOWN_WORD) == cls_q[p]) begin
        if (cnt_q[p] == 4'hF) link_d[p] = ~cls_q[p];
        else                  cnt_d[p]  = cnt_q[p] + 4'd1;
      end else begin
        cls_d[p] = ~cls_q[p];
        cnt_d[p] = 4'd1;
      end
      link_chg[p] = link_d[p] ^ link_q[p];
    end

    if (pps_i && !pps_q) pps_cnt_d = pps_cnt_q + 32'd1;

    if (wr) begin
      case (idx)
        6'h02:   w1c        = wb_dat_i & bmask;
        6'h03:   irq_mask_d = ((irq_mask_q & ~bmask) | (wb_dat_i & bmask)) & PORT_MASK;
        default: ;
      endcase
    end

    for (int p = 0; p < N; p++) begin
      if (wr && idx == 6'(16 + p)) begin
        if (wb_sel_i[3]) route_en_d[p]  = wb_dat_i[31];
        if (wb_sel_i[0]) route_src_d[p] = wb_dat_i[4:0];
      end
    end

    // A link change in the same cycle as a W1C of that bit keeps the bit set.
    irq_status_d = ((irq_status_q & ~w1c) | link_chg) & PORT_MASK;

    case (idx)
      6'h00:   rdata = ID_VALUE;
      6'h01:   rdata = 32'(link_q);
      6'h02:   rdata = irq_status_q;
      6'h03:   rdata = irq_mask_q;
      6'h04:   rdata = pps_cnt_q;
      default: rdata = '0;
    endcase
    for (int p = 0; p < N; p++) begin
      if (idx == 6'(16 + p)) rdata = {route_en_q[p], 26'b0, route_src_q[p]};
    end

    ack_d = acc;
    dat_d = (acc && !wb_we_i) ? rdata : '0;

    for (int p = 0; p < N; p++) begin
      td_d[p] = IDLE_WORD;
      if (route_en_q[p] && int'(route_src_q[p]) < N) td_d[p] = rd_i[18*route_src_q[p] +: 18];
    end
  end

  always_ff @(posedge clk_ref_i) begin
    if (!sys_rst_n_i) begin
      link_q       <= '0;
      cls_q        <= '0;
      cnt_q        <= '0;
      irq_status_q <= '0;
      irq_mask_q   <= '0;
      pps_cnt_q    <= '0;
      pps_q        <= 1'b0;
      route_en_q   <= '0;
      route_src_q  <= '0;
      td_q         <= {N{IDLE_WORD}};
      ack_q        <= 1'b0;
      dat_q        <= '0;
    end else begin
      link_q       <= link_d;
      cls_q        <= cls_d;
      cnt_q        <= cnt_d;
      irq_status_q <= irq_status_d;
      irq_mask_q   <= irq_mask_d;
      pps_cnt_q    <= pps_cnt_d;
      pps_q        <= pps_d;
      route_en_q   <= route_en_d;
      route_src_q  <= route_src_d;
      td_q         <= td_d;
      ack_q        <= ack_d;
      dat_q        <= dat_d;
    end
  end

  assign td_o       = td_q;
  assign wb_ack_o   = ack_q;
  assign wb_dat_o   = dat_q;
  assign wb_stall_o = 1'b0;
  assign wb_irq_o   = |(irq_status_q & irq_mask_q);

endmodule

// File: tb/tb_scb_sim_port_fabric.sv
// Directed bench for scb_sim_port_fabric: Wishbone transfers go through an expected-ack
// scoreboard, lanes and IRQ are checked against values worked out from the register map.
module tb_scb_sim_port_fabric;

  localparam int          N         = 18;
  localparam logic [17:0] IDLE_WORD = 18'h2BC50;
  localparam logic [17:0] DOWN_WORD = 18'h100BC;
  localparam logic [31:0] ID_VALUE  = 32'h5CB5_F00D;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [31:0]     adr, wdat, rdat;
  logic            cyc, stb, we, ack, stall, irq, pps;
  logic [3:0]      sel;
  logic [18*N-1:0] rd, td;

  typedef struct {
    bit          is_rd;
    logic [31:0] dat;
    int          cyc;
    string       tag;
  } sb_t;

  sb_t sb[$];
  int  cyc_n  = 0;
  int  checks = 0;
  int  errors = 0;

  always #5 clk = ~clk;

  scb_sim_port_fabric #(.g_num_ports(N)) dut (
    .clk_ref_i  (clk),
    .sys_rst_n_i(rst_n),
    .wb_adr_i   (adr),
    .wb_dat_i   (wdat),
    .wb_dat_o   (rdat),
    .wb_cyc_i   (cyc),
    .wb_stb_i   (stb),
    .wb_we_i    (we),
    .wb_sel_i   (sel),
    .wb_ack_o   (ack),
    .wb_stall_o (stall),
    .wb_irq_o   (irq),
    .pps_i      (pps),
    .rd_i       (rd),
    .td_o       (td)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pops the scoreboard entry due this cycle, otherwise the bus must be quiet.
  task automatic monitor();
    sb_t e;
    if (sb.size() != 0 && sb[0].cyc == cyc_n) begin
      e = sb.pop_front();
      chk({e.tag, "_ack"}, 32'(ack), 32'd1);
      if (e.is_rd) chk(e.tag, rdat, e.dat);
    end else begin
      chk("spurious_ack", 32'(ack), 32'd0);
    end
    chk("stall", 32'(stall), 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    cyc_n++;
    #1;
    monitor();
  endtask

  task automatic set_lane(input int p, input logic [17:0] v);
    rd[18*p +: 18] = v;
  endtask

  task automatic wb_xfer(input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [31:0] exp, input string tag);
    sb_t e;
    cyc  = 1'b1;
    stb  = 1'b1;
    we   = w;
    adr  = a;
    wdat = d;
    sel  = s;
    e.is_rd = !w;
    e.dat   = exp;
    e.cyc   = cyc_n + 1;
    e.tag   = tag;
    sb.push_back(e);
    tick();
  endtask

  task automatic wb_idle();
    cyc = 1'b0;
    stb = 1'b0;
    we  = 1'b0;
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input string tag);
    wb_xfer(1'b1, a, d, 4'hF, 32'd0, tag);
    wb_idle();
  endtask

  task automatic wb_read(input logic [31:0] a, input logic [31:0] exp, input string tag);
    wb_xfer(1'b0, a, 32'd0, 4'hF, exp, tag);
    wb_idle();
  endtask

  initial begin
    rst_n = 1'b0;
    adr   = '0;
    wdat  = '0;
    sel   = '0;
    pps   = 1'b0;
    wb_idle();
    for (int p = 0; p < N; p++) set_lane(p, DOWN_WORD);

    repeat (3) tick();
    for (int p = 0; p < N; p++) chk($sformatf("reset_td%0d", p), 32'(td[18*p +: 18]), 32'(IDLE_WORD));
    chk("reset_dat", rdat, 32'd0);
    chk("reset_irq", 32'(irq), 32'd0);
    rst_n = 1'b1;
    tick();

    wb_read(32'h00, ID_VALUE, "id");
    wb_read(32'h04, 32'd0, "link_after_reset");
    wb_write(32'h00, 32'h1234_5678, "id_write");
    wb_read(32'h00, ID_VALUE, "id_ro");

    // Port 3 comes up: 15 idle words are not enough, the 16th is.
    wb_write(32'h0C, 32'h8, "irq_mask");
    wb_read(32'h0C, 32'h8, "irq_mask_rb");
    set_lane(3, IDLE_WORD);
    repeat (15) tick();
    chk("irq_after_15_up", 32'(irq), 32'd0);
    tick();
    chk("irq_after_16_up", 32'(irq), 32'd1);
    wb_read(32'h04, 32'h8, "link_up");
    wb_read(32'h08, 32'h8, "irq_status_up");
    wb_write(32'h08, 32'h8, "irq_clear");
    chk("irq_cleared", 32'(irq), 32'd0);

    // 15 DOWN words then an idle word: link stays up.
    set_lane(3, DOWN_WORD);
    repeat (15) tick();
    set_lane(3, IDLE_WORD);
    tick();
    wb_read(32'h04, 32'h8, "link_15_down");
    chk("irq_15_down", 32'(irq), 32'd0);

    set_lane(3, DOWN_WORD);
    repeat (15) tick();
    chk("irq_before_down", 32'(irq), 32'd0);
    tick();
    chk("irq_after_down", 32'(irq), 32'd1);
    wb_read(32'h04, 32'd0, "link_down");
    wb_read(32'h08, 32'h8, "irq_status_down");
    wb_write(32'h08, 32'h8, "irq_clear2");
    wb_read(32'h08, 32'd0, "irq_status_clr2");

    // W1C lands on the same edge that the link comes back up: set wins.
    set_lane(3, IDLE_WORD);
    repeat (15) tick();
    wb_write(32'h08, 32'h8, "w1c_collide");
    wb_read(32'h08, 32'h8, "irq_set_wins");
    chk("irq_set_wins_out", 32'(irq), 32'd1);

    // Routing: ROUTE[7] at 0x5C selects lane 2.
    set_lane(2, 18'h1_1234);
    wb_write(32'h5C, 32'h8000_0002, "route7");
    chk("td7_before", 32'(td[18*7 +: 18]), 32'(IDLE_WORD));
    tick();
    chk("td7_route", 32'(td[18*7 +: 18]), 32'h1_1234);
    set_lane(2, 18'h3_0055);
    tick();
    chk("td7_follow", 32'(td[18*7 +: 18]), 32'h3_0055);
    wb_write(32'h40, 32'h8000_0002, "route0");
    tick();
    chk("td0_bcast", 32'(td[0 +: 18]), 32'h3_0055);
    chk("td7_bcast", 32'(td[18*7 +: 18]), 32'h3_0055);
    wb_write(32'h54, 32'h8000_0005, "route5");
    tick();
    chk("td5_loop", 32'(td[18*5 +: 18]), 32'(DOWN_WORD));
    wb_write(32'h5C, 32'h8000_001F, "route7_bad");
    tick();
    chk("td7_bad_src", 32'(td[18*7 +: 18]), 32'(IDLE_WORD));
    wb_read(32'h5C, 32'h8000_001F, "route7_rb");

    // Five back-to-back strobes, one ack expected per cycle.
    wb_xfer(1'b1, 32'h40, 32'h8000_0001, 4'hF, 32'd0, "b2b_wr");
    wb_xfer(1'b0, 32'h40, 32'd0, 4'hF, 32'h8000_0001, "b2b_rd");
    wb_xfer(1'b1, 32'h40, 32'h0000_0003, 4'b0001, 32'd0, "b2b_wr_sel");
    wb_xfer(1'b0, 32'h40, 32'd0, 4'hF, 32'h8000_0003, "b2b_rd_sel");
    wb_xfer(1'b0, 32'h20, 32'd0, 4'hF, 32'd0, "b2b_unmapped");
    wb_idle();
    tick();

    // Three pps pulses, the last one held for several cycles.
    wb_read(32'h10, 32'd0, "pps_zero");
    pps = 1'b1; tick(); pps = 1'b0; tick();
    pps = 1'b1; tick(); pps = 1'b0; tick();
    pps = 1'b1; repeat (3) tick(); pps = 1'b0; tick();
    wb_read(32'h10, 32'd3, "pps_cnt");

    tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
